// File: rtl/axi_rtio_cmd_slave.sv
// axi_rtio_cmd_slave
//   AXI4 responder terminating 128-bit PS write traffic for RTIO commands and
//   time-controller control words. Base decode happens upstream; only
//   addr[7:0] selects a register here:
//     0x00 CMD    : write pushes a full-strobe beat to the command FIFO,
//                   read returns status
//     0x10 CTRL   : 4-bit control register, read/write
//     0x20 STATUS : {fifo_full, push_count[31:0]}, read-only
//   Ports:
//     s_axi_aclk / s_axi_aresetn : clock, asynchronous active-low reset
//     s_axi_aw* / s_axi_w* / s_axi_b* : AXI4 write channels
//     s_axi_ar* / s_axi_r*        : AXI4 read channels
//     fifo_din / fifo_wr_en / fifo_full : command FIFO push port
//     ctrl_out / ctrl_wr_pulse    : control register and its write strobe
module axi_rtio_cmd_slave #(
  parameter int unsigned AXI_ADDR_WIDTH = 16,
  parameter int unsigned AXI_ID_WIDTH   = 1
) (
  input  logic                      s_axi_aclk,
  input  logic                      s_axi_aresetn,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_awid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]                s_axi_awlen,
  input  logic [2:0]                s_axi_awsize,
  input  logic [1:0]                s_axi_awburst,
  input  logic                      s_axi_awvalid,
  output logic                      s_axi_awready,
  input  logic [127:0]              s_axi_wdata,
  input  logic [15:0]               s_axi_wstrb,
  input  logic                      s_axi_wlast,
  input  logic                      s_axi_wvalid,
  output logic                      s_axi_wready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]                s_axi_bresp,
  output logic                      s_axi_bvalid,
  input  logic                      s_axi_bready,
  input  logic [AXI_ID_WIDTH-1:0]   s_axi_arid,
  input  logic [AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic [7:0]                s_axi_arlen,
  input  logic                      s_axi_arvalid,
  output logic                      s_axi_arready,
  output logic [AXI_ID_WIDTH-1:0]   s_axi_rid,
  output logic [127:0]              s_axi_rdata,
  output logic [1:0]                s_axi_rresp,
  output logic                      s_axi_rlast,
  output logic                      s_axi_rvalid,
  input  logic                      s_axi_rready,
  output logic [127:0]              fifo_din,
  output logic                      fifo_wr_en,
  input  logic                      fifo_full,
  output logic [3:0]                ctrl_out,
  output logic                      ctrl_wr_pulse
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;
  typedef enum logic [1:0] {T_CMD, T_CTRL, T_STATUS, T_NONE} tgt_e;

  function automatic tgt_e decode(input logic [7:0] off);
    case (off)
      8'h00:   return T_CMD;
      8'h10:   return T_CTRL;
      8'h20:   return T_STATUS;
      default: return T_NONE;
    endcase
  endfunction

  // Write side state
  w_state_e                w_state_q, w_state_d;
  tgt_e                    w_tgt_q, w_tgt_d;
  logic [AXI_ID_WIDTH-1:0] wid_q, wid_d;
  logic [7:0]              wlen_q, wlen_d;
  logic [7:0]              wbeat_q, wbeat_d;
  logic                    slverr_q, slverr_d;
  logic                    decerr_q, decerr_d;
  logic                    awready_q, awready_d;
  logic                    bvalid_q, bvalid_d;
  logic [3:0]              ctrl_q, ctrl_d;
  logic                    ctrl_pulse_q, ctrl_pulse_d;
  logic [31:0]             push_cnt_q, push_cnt_d;
  logic                    wready;
  logic                    push;
  logic                    last_beat;

  // Read side state
  r_state_e                r_state_q, r_state_d;
  tgt_e                    r_tgt_q, r_tgt_d;
  logic [AXI_ID_WIDTH-1:0] rid_q, rid_d;
  logic [7:0]              rlen_q, rlen_d;
  logic [7:0]              rbeat_q, rbeat_d;
  logic                    arready_q, arready_d;
  logic                    rvalid_q, rvalid_d;
  logic [127:0]            rdata;
  logic [1:0]              rresp;

  always_comb begin
    w_state_d    = w_state_q;
    w_tgt_d      = w_tgt_q;
    wid_d        = wid_q;
    wlen_d       = wlen_q;
    wbeat_d      = wbeat_q;
    slverr_d     = slverr_q;
    decerr_d     = decerr_q;
    ctrl_d       = ctrl_q;
    ctrl_pulse_d = 1'b0;
    push_cnt_d   = push_cnt_q;
    wready       = 1'b0;
    push         = 1'b0;
    last_beat    = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid && awready_q) begin
          w_tgt_d   = decode(s_axi_awaddr[7:0]);
          wid_d     = s_axi_awid;
          wlen_d    = s_axi_awlen;
          wbeat_d   = '0;
          slverr_d  = 1'b0;
          decerr_d  = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        // Only the CMD target back-pressures on the FIFO, so a full FIFO
        // can never see a push.
        wready = (w_tgt_q == T_CMD) ? ~fifo_full : 1'b1;
        if (s_axi_wvalid && wready) begin
          last_beat = (wbeat_q == wlen_q);
          // Beat count alone ends the burst; a disagreeing wlast is only
          // reported.
          if (s_axi_wlast != last_beat) slverr_d = 1'b1;
          case (w_tgt_q)
            T_CMD: begin
              if (&s_axi_wstrb) begin
                push       = 1'b1;
                push_cnt_d = push_cnt_q + 32'd1;
              end else begin
                slverr_d = 1'b1;
              end
            end
            T_CTRL: begin
              if (s_axi_wstrb[0]) begin
                ctrl_d       = s_axi_wdata[3:0];
                ctrl_pulse_d = 1'b1;
              end
            end
            T_STATUS: slverr_d = 1'b1;
            default:  decerr_d = 1'b1;
          endcase
          wbeat_d = wbeat_q + 8'd1;
          if (last_beat) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (s_axi_bready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    // Handshake outputs are registered from the next state so that they
    // stay low while reset is held.
    awready_d = (w_state_d == W_IDLE);
    bvalid_d  = (w_state_d == W_RESP);
  end

  always_comb begin
    r_state_d = r_state_q;
    r_tgt_d   = r_tgt_q;
    rid_d     = rid_q;
    rlen_d    = rlen_q;
    rbeat_d   = rbeat_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid && arready_q) begin
          r_tgt_d   = decode(s_axi_araddr[7:0]);
          rid_d     = s_axi_arid;
          rlen_d    = s_axi_arlen;
          rbeat_d   = '0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          if (rbeat_q == rlen_q) r_state_d = R_IDLE;
          else                   rbeat_d   = rbeat_q + 8'd1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  // Read data is built from live register values each beat, so a control
  // write landing in the same cycle is not yet visible.
  always_comb begin
    rdata = '0;
    rresp = RESP_OKAY;
    if (rvalid_q) begin
      case (r_tgt_q)
        T_CMD, T_STATUS: rdata = {95'b0, fifo_full, push_cnt_q};
        T_CTRL:          rdata = {124'b0, ctrl_q};
        default:         rresp = RESP_DECERR;
      endcase
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      w_state_q    <= W_IDLE;
      w_tgt_q      <= T_CMD;
      wid_q        <= '0;
      wlen_q       <= '0;
      wbeat_q      <= '0;
      slverr_q     <= 1'b0;
      decerr_q     <= 1'b0;
      awready_q    <= 1'b0;
      bvalid_q     <= 1'b0;
      ctrl_q       <= '0;
      ctrl_pulse_q <= 1'b0;
      push_cnt_q   <= '0;
      r_state_q    <= R_IDLE;
      r_tgt_q      <= T_CMD;
      rid_q        <= '0;
      rlen_q       <= '0;
      rbeat_q      <= '0;
      arready_q    <= 1'b0;
      rvalid_q     <= 1'b0;
    end else begin
      w_state_q    <= w_state_d;
      w_tgt_q      <= w_tgt_d;
      wid_q        <= wid_d;
      wlen_q       <= wlen_d;
      wbeat_q      <= wbeat_d;
      slverr_q     <= slverr_d;
      decerr_q     <= decerr_d;
      awready_q    <= awready_d;
      bvalid_q     <= bvalid_d;
      ctrl_q       <= ctrl_d;
      ctrl_pulse_q <= ctrl_pulse_d;
      push_cnt_q   <= push_cnt_d;
      r_state_q    <= r_state_d;
      r_tgt_q      <= r_tgt_d;
      rid_q        <= rid_d;
      rlen_q       <= rlen_d;
      rbeat_q      <= rbeat_d;
      arready_q    <= arready_d;
      rvalid_q     <= rvalid_d;
    end
  end

  assign s_axi_awready = awready_q;
  assign s_axi_wready  = wready;
  assign s_axi_bvalid  = bvalid_q;
  assign s_axi_bid     = wid_q;
  assign s_axi_bresp   = decerr_q ? RESP_DECERR : (slverr_q ? RESP_SLVERR : RESP_OKAY);
  assign s_axi_arready = arready_q;
  assign s_axi_rvalid  = rvalid_q;
  assign s_axi_rid     = rid_q;
  assign s_axi_rdata   = rdata;
  assign s_axi_rresp   = rresp;
  assign s_axi_rlast   = rvalid_q && (rbeat_q == rlen_q);
  assign fifo_din      = s_axi_wdata;
  assign fifo_wr_en    = push;
  assign ctrl_out      = ctrl_q;
  assign ctrl_wr_pulse = ctrl_pulse_q;

  // Size/burst type are irrelevant (every beat hits one register) and the
  // upper address bits are decoded upstream.
  logic unused_ok;
  assign unused_ok = ^{s_axi_awaddr[AXI_ADDR_WIDTH-1:8], s_axi_araddr[AXI_ADDR_WIDTH-1:8],
                       s_axi_awsize, s_axi_awburst};

endmodule
